// File: rtl/ram_block_mover_if.sv
// Command/status handshake plus RAM8K port bundle for the block mover.
// master = sequencer side that also owns the RAM; slave = the mover.
interface ram_block_mover_if #(
   parameter int unsigned AW = 13,
   parameter int unsigned DW = 16
);
   logic          start;
   logic          op;
   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [AW:0]   len;
   logic [DW-1:0] fill_val;
   logic          busy;
   logic          done;
   logic [DW-1:0] ram_in;
   logic          ram_load;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_out;

   modport master (
      output start, op, src, dst, len, fill_val, ram_out,
      input  busy, done, ram_in, ram_load, ram_address
   );

   modport slave (
      input  start, op, src, dst, len, fill_val, ram_out,
      output busy, done, ram_in, ram_load, ram_address
   );
endinterface

// File: rtl/ram_block_mover.sv
// Fill/copy engine driving a RAM8K-style memory: one word per cycle for FILL,
// one read + one write cycle per word for COPY, with busy/done reporting.
module ram_block_mover #(
   parameter int unsigned AW = 13,
   parameter int unsigned DW = 16
) (
   input logic            clk,
   input logic            reset_n,
   ram_block_mover_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StFill, StCrd, StCwr, StDone} state_e;

   state_e        state_q, state_d;
   logic [AW:0]   i_q;
   logic [AW:0]   len_q;
   logic [AW-1:0] src_q;
   logic [AW-1:0] dst_q;
   logic [DW-1:0] fill_q;
   logic [DW-1:0] d_q;
   logic          last;

   // len_q is never 0 outside IDLE/DONE, so len_q-1 cannot underflow where used.
   assign last = (i_q == (len_q - {{AW{1'b0}}, 1'b1}));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (bus.len == '0) begin
                  state_d = StDone;
               end else if (bus.op) begin
                  state_d = StCrd;
               end else begin
                  state_d = StFill;
               end
            end
         end
         StFill:  if (last) state_d = StDone;
         StCrd:   state_d = StCwr;
         StCwr:   state_d = last ? StDone : StCrd;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.busy        = 1'b0;
      bus.done        = 1'b0;
      bus.ram_load    = 1'b0;
      bus.ram_address = '0;
      bus.ram_in      = '0;
      unique case (state_q)
         StFill: begin
            bus.busy        = 1'b1;
            bus.ram_load    = 1'b1;
            bus.ram_address = dst_q + i_q[AW-1:0];
            bus.ram_in      = fill_q;
         end
         StCrd: begin
            bus.busy        = 1'b1;
            bus.ram_address = src_q + i_q[AW-1:0];
         end
         StCwr: begin
            bus.busy        = 1'b1;
            bus.ram_load    = 1'b1;
            bus.ram_address = dst_q + i_q[AW-1:0];
            bus.ram_in      = d_q;
         end
         StDone:  bus.done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i_q    <= '0;
         len_q  <= '0;
         src_q  <= '0;
         dst_q  <= '0;
         fill_q <= '0;
         d_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  i_q    <= '0;
                  len_q  <= bus.len;
                  src_q  <= bus.src;
                  dst_q  <= bus.dst;
                  fill_q <= bus.fill_val;
               end
            end
            StFill:  i_q <= i_q + 1'b1;
            StCrd:   d_q <= bus.ram_out;
            StCwr:   i_q <= i_q + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: behavioural RAM, array-based reference model,
// directed scenarios plus randomized fill/copy commands.
module tb_ram_block_mover;
   localparam int AW    = 13;
   localparam int DW    = 16;
   localparam int Words = 8192;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ram_block_mover_if #(.AW(AW), .DW(DW)) bus ();

   ram_block_mover #(.AW(AW), .DW(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   logic [DW-1:0] mem     [Words];
   logic [DW-1:0] ref_mem [Words];

   assign bus.ram_out = mem[bus.ram_address];
   always @(posedge clk) if (bus.ram_load === 1'b1) mem[bus.ram_address] <= bus.ram_in;

   int checks = 0;
   int errors = 0;

   // Ascending word-by-word semantics, so overlapping copies see earlier writes.
   task automatic model_cmd(input logic o, input int s, input int d, input int n,
                            input logic [DW-1:0] f);
      for (int k = 0; k < n; k++) begin
         if (o) ref_mem[(d + k) % Words] = ref_mem[(s + k) % Words];
         else   ref_mem[(d + k) % Words] = f;
      end
   endtask

   function automatic int mem_diffs();
      int c = 0;
      for (int k = 0; k < Words; k++) if (mem[k] !== ref_mem[k]) c++;
      return c;
   endfunction

   task automatic preset(input int a, input logic [DW-1:0] v);
      mem[a % Words]     = v;
      ref_mem[a % Words] = v;
   endtask

   // Issues one command and observes outputs #1 after E0, E1, ... (sample j).
   // poke >= 0 raises start with other arguments for one cycle at sample poke.
   task automatic run_cmd(input logic o, input int s, input int d, input int n,
                          input logic [DW-1:0] f, input int poke,
                          output int busy_cnt, output int load_cnt,
                          output int done_idx, output int done_cnt);
      int limit;
      limit = 2 * n + 6;
      busy_cnt = 0; load_cnt = 0; done_idx = -1; done_cnt = 0;
      @(negedge clk);
      bus.op = o; bus.src = AW'(s); bus.dst = AW'(d);
      bus.len = (AW + 1)'(n); bus.fill_val = f; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op = 1'($urandom); bus.src = AW'($urandom); bus.dst = AW'($urandom);
      bus.len = (AW + 1)'($urandom); bus.fill_val = DW'($urandom);
      for (int j = 0; j < limit; j++) begin
         if (j == poke) begin
            bus.start = 1'b1; bus.op = 1'b0; bus.dst = AW'(d + 100);
            bus.len = 14'd3; bus.fill_val = ~f;
         end else if (j == poke + 1) begin
            bus.start = 1'b0;
         end
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.ram_load === 1'b1) load_cnt++;
         if (bus.done === 1'b1) begin
            if (done_idx < 0) done_idx = j;
            done_cnt++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++;
         $display("FAIL reset busy actual=%b required=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++;
         $display("FAIL reset done actual=%b required=0", bus.done); end
      checks++; if (bus.ram_load !== 1'b0) begin errors++;
         $display("FAIL reset ram_load actual=%b required=0", bus.ram_load); end
      checks++; if (bus.ram_address !== '0) begin errors++;
         $display("FAIL reset ram_address actual=%0d required=0", bus.ram_address); end
      checks++; if (bus.ram_in !== '0) begin errors++;
         $display("FAIL reset ram_in actual=%0d required=0", bus.ram_in); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_fill();
      int dsts [2] = '{500, 8190};
      int vals [2] = '{7, 9};
      int bc, lc, di, dc;
      for (int t = 0; t < 2; t++) begin
         run_cmd(1'b0, 0, dsts[t], 4, DW'(vals[t]), -1, bc, lc, di, dc);
         model_cmd(1'b0, 0, dsts[t], 4, DW'(vals[t]));
         checks++; if (bc !== 4) begin errors++;
            $display("FAIL fill%0d busy_cycles actual=%0d required=4", t, bc); end
         checks++; if (lc !== 4) begin errors++;
            $display("FAIL fill%0d load_cycles actual=%0d required=4", t, lc); end
         checks++; if (di !== 4 || dc !== 1) begin errors++;
            $display("FAIL fill%0d done actual=idx%0d/cnt%0d required=idx4/cnt1", t, di, dc); end
         checks++; if (mem_diffs() !== 0) begin errors++;
            $display("FAIL fill%0d ram_contents actual=%0d bad words required=0", t, mem_diffs()); end
      end
   endtask

   task automatic test_copy();
      int bc, lc, di, dc;
      preset(1000, 16'd11); preset(1001, 16'd22); preset(1002, 16'd33);
      run_cmd(1'b1, 1000, 2000, 3, 16'h0, -1, bc, lc, di, dc);
      model_cmd(1'b1, 1000, 2000, 3, 16'h0);
      checks++; if (bc !== 6) begin errors++;
         $display("FAIL copy busy_cycles actual=%0d required=6", bc); end
      checks++; if (lc !== 3) begin errors++;
         $display("FAIL copy load_cycles actual=%0d required=3", lc); end
      checks++; if (di !== 6 || dc !== 1) begin errors++;
         $display("FAIL copy done actual=idx%0d/cnt%0d required=idx6/cnt1", di, dc); end
      checks++; if (mem[2000] !== 16'd11 || mem[2001] !== 16'd22 || mem[2002] !== 16'd33) begin
         errors++;
         $display("FAIL copy dest actual=%0d,%0d,%0d required=11,22,33",
                  mem[2000], mem[2001], mem[2002]); end
      checks++; if (mem_diffs() !== 0) begin errors++;
         $display("FAIL copy ram_contents actual=%0d bad words required=0", mem_diffs()); end
   endtask

   task automatic test_zero_len();
      int bc, lc, di, dc;
      for (int o = 0; o < 2; o++) begin
         run_cmd(1'(o), 100, 200, 0, 16'hBEEF, -1, bc, lc, di, dc);
         checks++; if (bc !== 0 || lc !== 0) begin errors++;
            $display("FAIL zero_len%0d activity actual=busy%0d/load%0d required=0/0", o, bc, lc); end
         checks++; if (di !== 0 || dc !== 1) begin errors++;
            $display("FAIL zero_len%0d done actual=idx%0d/cnt%0d required=idx0/cnt1", o, di, dc); end
      end
      checks++; if (mem_diffs() !== 0) begin errors++;
         $display("FAIL zero_len ram_contents actual=%0d bad words required=0", mem_diffs()); end
   endtask

   task automatic test_abort();
      int bc, lc, di, dc, seen_done;
      logic load_before;
      for (int a = 3000; a < 3010; a++) preset(a, 16'hAAAA);
      @(negedge clk);
      bus.op = 1'b0; bus.dst = 13'd3000; bus.len = 14'd8; bus.fill_val = 16'd5;
      bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      load_before = bus.ram_load;
      reset_n = 1'b0;
      #1;
      checks++; if (load_before !== 1'b1) begin errors++;
         $display("FAIL abort load_before_reset actual=%b required=1", load_before); end
      checks++; if ({bus.busy, bus.done, bus.ram_load} !== 3'b000 || bus.ram_address !== '0
                    || bus.ram_in !== '0) begin errors++;
         $display("FAIL abort outputs_in_reset actual=%b%b%b addr=%0d in=%0d required=000/0/0",
                  bus.busy, bus.done, bus.ram_load, bus.ram_address, bus.ram_in); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      seen_done = 0;
      for (int j = 0; j < 12; j++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1 || bus.ram_load === 1'b1) seen_done++;
      end
      checks++; if (seen_done !== 0) begin errors++;
         $display("FAIL abort activity_after actual=%0d required=0", seen_done); end
      model_cmd(1'b0, 0, 3000, 3, 16'd5);
      checks++; if (mem_diffs() !== 0) begin errors++;
         $display("FAIL abort ram_contents actual=%0d bad words required=0", mem_diffs()); end
      run_cmd(1'b0, 0, 3004, 5, 16'd6, -1, bc, lc, di, dc);
      model_cmd(1'b0, 0, 3004, 5, 16'd6);
      checks++; if (bc !== 5 || di !== 5 || dc !== 1) begin errors++;
         $display("FAIL abort next_cmd actual=busy%0d/idx%0d/cnt%0d required=5/5/1", bc, di, dc); end
      checks++; if (mem_diffs() !== 0) begin errors++;
         $display("FAIL abort next_ram actual=%0d bad words required=0", mem_diffs()); end
   endtask

   task automatic test_start_while_busy();
      int bc, lc, di, dc;
      run_cmd(1'b0, 0, 5000, 6, 16'h1357, 2, bc, lc, di, dc);
      model_cmd(1'b0, 0, 5000, 6, 16'h1357);
      checks++; if (bc !== 6 || lc !== 6) begin errors++;
         $display("FAIL busy_start cycles actual=busy%0d/load%0d required=6/6", bc, lc); end
      checks++; if (di !== 6 || dc !== 1) begin errors++;
         $display("FAIL busy_start done actual=idx%0d/cnt%0d required=idx6/cnt1", di, dc); end
      checks++; if (mem_diffs() !== 0) begin errors++;
         $display("FAIL busy_start ram_contents actual=%0d bad words required=0", mem_diffs()); end
   endtask

   task automatic test_back_to_back();
      logic exp_busy, exp_done;
      @(negedge clk);
      bus.op = 1'b0; bus.dst = 13'd4000; bus.len = 14'd2; bus.fill_val = 16'h1234;
      bus.start = 1'b1;
      @(posedge clk); #1;
      for (int j = 0; j < 12; j++) begin
         // Two accepted commands of 2 words each, spaced len+2 = 4 edges apart.
         exp_busy = (j < 8) && ((j % 4) < 2);
         exp_done = (j < 8) && ((j % 4) == 2);
         checks++; if (bus.busy !== exp_busy || bus.done !== exp_done) begin errors++;
            $display("FAIL b2b sample%0d actual=busy%b/done%b required=busy%b/done%b",
                     j, bus.busy, bus.done, exp_busy, exp_done); end
         if (j == 0) begin bus.dst = 13'd4010; bus.fill_val = 16'h5678; end
         if (j == 4) bus.start = 1'b0;
         @(posedge clk); #1;
      end
      model_cmd(1'b0, 0, 4000, 2, 16'h1234);
      model_cmd(1'b0, 0, 4010, 2, 16'h5678);
      checks++; if (mem_diffs() !== 0) begin errors++;
         $display("FAIL b2b ram_contents actual=%0d bad words required=0", mem_diffs()); end
   endtask

   task automatic test_random();
      int bc, lc, di, dc, s, d, n, eb;
      logic o;
      logic [DW-1:0] f;
      for (int t = 0; t < 25; t++) begin
         o = 1'($urandom);
         s = ($urandom % 2 == 0) ? Words - 1 - int'($urandom_range(0, 20)) : int'($urandom % Words);
         d = ($urandom % 2 == 0) ? (s + int'($urandom_range(1, 8))) % Words : int'($urandom % Words);
         n = $urandom_range(0, 40);
         f = DW'($urandom);
         run_cmd(o, s, d, n, f, -1, bc, lc, di, dc);
         model_cmd(o, s, d, n, f);
         eb = o ? 2 * n : n;
         checks++; if (bc !== eb || lc !== n) begin errors++;
            $display("FAIL rand%0d cycles actual=busy%0d/load%0d required=%0d/%0d", t, bc, lc, eb, n); end
         checks++; if (di !== eb || dc !== 1) begin errors++;
            $display("FAIL rand%0d done actual=idx%0d/cnt%0d required=idx%0d/cnt1", t, di, dc, eb); end
         checks++; if (mem_diffs() !== 0) begin errors++;
            $display("FAIL rand%0d ram_contents op=%0d src=%0d dst=%0d len=%0d actual=%0d bad words required=0",
                     t, o, s, d, n, mem_diffs()); end
      end
   endtask

   initial begin
      logic [DW-1:0] v;
      bus.start = 1'b0; bus.op = 1'b0; bus.src = '0; bus.dst = '0;
      bus.len = '0; bus.fill_val = '0;
      for (int k = 0; k < Words; k++) begin
         v = DW'($urandom);
         mem[k] = v;
         ref_mem[k] = v;
      end
      test_reset();
      test_fill();
      test_copy();
      test_zero_len();
      test_abort();
      test_start_while_busy();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=completion");
      $fatal(1, "watchdog expired");
   end
endmodule
